// File: rtl/rr_decode_arbiter.sv
// ============================================================================
//  Module   : rr_decode_arbiter
//  Purpose  : 8-way round-robin arbiter with one-hot grant, hold limit with
//             timeout pulse, and a mandatory dead cycle between owners.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_decode_arbiter #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [3:0] C_HOLD_MAX = 4'(HOLD_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_grant,   w_grant_nxt;
    logic [2:0] r_gnt_idx, w_gnt_idx_nxt;
    logic       r_valid,   w_valid_nxt;
    logic       r_timeout, w_timeout_nxt;
    logic [3:0] r_cnt,     w_cnt_nxt;
    logic [2:0] r_last,    w_last_nxt;

    logic       w_found;
    logic [2:0] w_win;
    logic [2:0] w_cand;
    logic       w_at_max;
    logic       w_owner_req;
    logic       w_release;
    logic       w_revoke;

    // Search begins just past the previous owner and wraps; first hit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_cand  = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            w_cand = r_last + 3'(i);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_at_max    = (r_cnt == C_HOLD_MAX);
    assign w_owner_req = req[r_gnt_idx];
    assign w_release   = done | ~w_owner_req | w_at_max;
    // Voluntary release (done or request drop) masks the timeout.
    assign w_revoke    = w_at_max & ~done & w_owner_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gnt_idx_nxt = r_gnt_idx;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_idx_nxt = w_win;
                    w_grant_nxt   = 8'b1 << w_win;
                    w_valid_nxt   = 1'b1;
                    w_cnt_nxt     = 4'd1;
                    w_state_nxt   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_grant_nxt   = 8'h00;
                    w_valid_nxt   = 1'b0;
                    w_last_nxt    = r_gnt_idx;
                    w_timeout_nxt = w_revoke;
                    w_cnt_nxt     = 4'd0;
                    w_state_nxt   = S_GAP;
                end else if (!w_at_max) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant   <= 8'h00;
            r_gnt_idx <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= 4'd0;
            r_last    <= 3'd7;
        end else begin
            r_grant   <= w_grant_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
        end
    end

    assign grant     = r_grant;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_valid = r_valid;
    assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_decode_arbiter.sv
// ============================================================================
//  Module   : tb_rr_decode_arbiter
//  Purpose  : Directed self-checking bench for rr_decode_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_decode_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks;
    int n_errors;

    rr_decode_arbiter #(.HOLD_MAX(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic step;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"},   32'(grant),     32'h00);
        check({tag, "_valid"},   32'(gnt_valid), 32'h0);
        check({tag, "_timeout"}, 32'(timeout),   32'h0);
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        req      = 8'h00;
        done     = 1'b0;
        n_checks = 0;
        n_errors = 0;

        // Reset state, with done/req noise that must be ignored
        step;
        req  = 8'hFF;
        done = 1'b1;
        step;
        check_idle("rst");
        check("rst_idx", 32'(gnt_idx), 32'h0);
        req  = 8'h00;
        done = 1'b0;
        rst_n = 1'b1;

        // No requests for 5 cycles
        for (int i = 0; i < 5; i++) begin
            step;
            check_idle("noreq");
        end

        // Round robin 0..7,0 with done one cycle after each grant
        req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            step;
            check("rr_grant", 32'(grant),     32'(8'h01 << (k % 8)));
            check("rr_idx",   32'(gnt_idx),   32'(k % 8));
            check("rr_valid", 32'(gnt_valid), 32'h1);
            done = 1'b1;
            step;
            check_idle("rr_rel");
            done = 1'b0;
            step;
            check_idle("rr_gap");
        end
        req = 8'h00;

        // Single requester 3 held: 15 grant cycles, timeout, 2 idle, re-grant
        step;
        req = 8'h08;
        step;
        for (int c = 1; c <= 15; c++) begin
            check("hold_grant",   32'(grant),   32'h08);
            check("hold_timeout", 32'(timeout), 32'h0);
            // Other request bits toggling while owned must not matter
            req = (c < 14 && c[0]) ? 8'hFF : 8'h08;
            step;
        end
        check("to_grant", 32'(grant),   32'h00);
        check("to_pulse", 32'(timeout), 32'h1);
        step;
        check_idle("to_gap");
        step;
        check("regrant", 32'(grant),   32'h08);
        check("regrant_to", 32'(timeout), 32'h0);
        req = 8'h00;
        step;
        check_idle("drop3");
        step;
        step;

        // Establish last=2, then req=8'h24 -> 5 first, then 2
        req = 8'h04;
        step;
        check("own2", 32'(grant), 32'h04);
        done = 1'b1;
        req  = 8'h00;
        step;
        done = 1'b0;
        step;
        req = 8'h24;
        step;
        check("rr24_first", 32'(grant), 32'h20);
        done = 1'b1;
        step;
        check_idle("rr24_rel");
        done = 1'b0;
        step;
        step;
        check("rr24_second", 32'(grant),   32'h04);
        check("rr24_idx",    32'(gnt_idx), 32'h2);

        // Release owner 2, regrant 5, then drop req[5] together with done
        done = 1'b1;
        step;
        done = 1'b0;
        step;
        step;
        check("own5", 32'(grant), 32'h20);
        req  = 8'h04;
        done = 1'b1;
        step;
        check_idle("drop5");
        check("drop5_idx", 32'(gnt_idx), 32'h5);
        req  = 8'h00;
        done = 1'b0;
        step;
        step;

        // Reset while owning index 4, then req=8'h11 goes to index 0
        req = 8'h10;
        step;
        check("own4", 32'(grant), 32'h10);
        rst_n = 1'b0;
        step;
        check_idle("midrst");
        check("midrst_idx", 32'(gnt_idx), 32'h0);
        rst_n = 1'b1;
        req   = 8'h11;
        step;
        check("postrst_grant", 32'(grant),   32'h01);
        check("postrst_idx",   32'(gnt_idx), 32'h0);
        req = 8'h00;
        step;
        step;
        step;

        // done arriving exactly at the hold limit suppresses timeout
        req = 8'h08;
        for (int c = 1; c <= 15; c++) begin
            step;
        end
        check("lim_grant", 32'(grant), 32'h08);
        done = 1'b1;
        step;
        check_idle("lim_done");
        done = 1'b0;
        req  = 8'h00;
        step;
        check("lim_after", 32'(timeout), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_decode_arbiter.md
RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 15, maximum consecutive grant cycles per ownership; legal range 1..15.
REQ-002 Ports: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Ports: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Ports: req  input  8  request lines; req[i] high = requester i wants the shared resource.
REQ-005 Ports: done  input  1  owner releases the resource; sampled only in BUSY.
REQ-006 Ports: grant  output  8  one-hot grant, 3-to-8 decode of gnt_idx; all-zero when gnt_valid low.
REQ-007 Ports: gnt_idx  output  3  binary index of current owner.
REQ-008 Ports: gnt_valid  output  1  high while a grant is held.
REQ-009 Ports: timeout  output  1  one-cycle pulse when an ownership is revoked by HOLD_MAX.
REQ-010 All outputs are registered; no combinational path from inputs to outputs.

Function
REQ-011 FSM states: IDLE, BUSY, GAP; encoding is implementation choice.
REQ-012 IDLE: if req != 0 at an edge, select winner, load gnt_idx, set gnt_valid, clear hold counter to 1, go BUSY; else stay IDLE.
REQ-013 Winner selection: round-robin; search starts at (last + 1) mod 8 and wraps, first set req bit wins; last = index of most recent owner.
REQ-014 Latency: req sampled high in IDLE at edge N -> grant/gnt_valid visible after edge N (one cycle).
REQ-015 BUSY: grant held constant; hold counter increments each cycle, saturating at HOLD_MAX.
REQ-016 BUSY release conditions, checked at each edge: done high, or req[gnt_idx] low, or counter == HOLD_MAX.
REQ-017 On release: gnt_valid, grant cleared after that edge; last <= gnt_idx; go GAP.
REQ-018 Simultaneous release causes: done or req drop takes priority; timeout asserted only when counter == HOLD_MAX and done low and req[gnt_idx] high.
REQ-019 timeout is high for exactly the one cycle following the revoking edge, low otherwise.
REQ-020 GAP: exactly one cycle, no grant; unconditionally go IDLE (mandatory dead cycle between owners).
REQ-021 gnt_idx retains last owner's value while gnt_valid low.
REQ-022 Changes on req bits other than req[gnt_idx] during BUSY have no effect.
REQ-023 done high in IDLE or GAP is ignored.
REQ-024 Single continuous requester: re-granted after GAP+IDLE, i.e. ownerships separated by 2 cycles with grant low.
REQ-025 Hold counter width 4 bits; never wraps.

Reset
REQ-026 rst_n low at an edge: state IDLE, grant 8'h00, gnt_idx 0, gnt_valid 0, timeout 0, counter 0, last 7 (so first search starts at index 0).
REQ-027 Reset mid-BUSY drops grant after that edge; no timeout pulse generated.
REQ-028 rst_n has priority over every other input.

Verification
REQ-029 Reset, then req=8'h00 for 5 cycles -> grant 8'h00, gnt_valid 0, timeout 0 throughout.
REQ-030 After reset req=8'hFF held, done pulsed 1 cycle after each grant -> owners in order 0,1,2,...,7,0; grant 8'h01,8'h02,...,8'h80,8'h01.
REQ-031 req=8'h08 held, done never -> grant 8'h08 for exactly 15 cycles, timeout pulse once, 2 cycles no grant, re-grant 8'h08.
REQ-032 req=8'h24 with last=2 -> grant 8'h20 first; on done, grant 8'h04 after GAP.
REQ-033 Owner 5 drops req[5] while done high same edge -> release, timeout stays 0.
REQ-034 rst_n low during BUSY (grant 8'h10) -> all outputs reset after that edge; next grant with req=8'h11 goes to index 0.
